even_parity_frame_ctrl: RTL and testbench

Serial frame receiver and sequencer for the 4-bit even-parity check path. It assembles start/data/parity/stop frames from a bit-enable-qualified serial line and runs the even-parity check on each completed word. Checked words are presented through a single-entry valid/ready output buffer. The block also keeps a saturating parity-error counter and flags framing errors and buffer overruns.

---
 rtl/even_parity_pkg.sv | 25 ++
 rtl/even_parity_chk_core.sv | 19 +
 rtl/even_parity_frame_ctrl.sv | 150 +++++++++++++++
 tb/tb_even_parity_frame_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/even_parity_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// even_parity_pkg : shared FSM states, default widths, parity reduction
// Rev 1.0
// ----------------------------------------------------------------------------
package even_parity_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_e;

  localparam int DEF_DATA_W = 4;
  localparam int DEF_CNT_W  = 8;
  localparam int MAX_DATA_W = 32;

  // Callers zero-extend their word; the padding bits do not change the XOR.
  function automatic logic parity_err(input logic [MAX_DATA_W-1:0] data, input logic p);
    return (^data) ^ p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/even_parity_chk_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// even_parity_chk_core : combinational even-parity check, perr=1 on error
// Rev 1.0
// ----------------------------------------------------------------------------
module even_parity_chk_core
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              p_i,
  output logic              perr_o
);

  assign perr_o = parity_err(MAX_DATA_W'(data_i), p_i);

endmodule
`default_nettype wire

// File: rtl/even_parity_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// even_parity_frame_ctrl : serial frame receiver with parity check, 1-entry
// valid/ready output buffer and saturating parity-error counter. Rev 1.0
// ----------------------------------------------------------------------------
module even_parity_frame_ctrl
  import even_parity_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bit_en,
  input  logic              rx_bit,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_perr,
  output logic              frame_err,
  output logic              overrun,
  output logic [CNT_W-1:0]  perr_count,
  input  logic              clr_count,
  output logic              busy
);

  localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                par_q, par_d;
  logic                out_valid_q, out_valid_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                out_perr_q, out_perr_d;
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                frame_done;
  logic                stop_bad;
  logic                buf_free;
  logic                perr;

  even_parity_chk_core #(
    .DATA_W (DATA_W)
  ) u_chk (
    .data_i (shift_q),
    .p_i    (par_q),
    .perr_o (perr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      idx_q       <= '0;
      par_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_perr_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      idx_q       <= idx_d;
      par_q       <= par_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_perr_q  <= out_perr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      cnt_q       <= cnt_d;
    end
  end

  // Frame FSM: every transition is gated by bit_en.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    idx_d      = idx_q;
    par_d      = par_q;
    frame_done = 1'b0;
    stop_bad   = 1'b0;
    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!rx_bit) begin
            state_d = DATA;
            idx_d   = '0;
          end
        end
        DATA: begin
          for (int i = 0; i < DATA_W; i++) begin
            if (idx_q == IDX_W'(i)) shift_d[i] = rx_bit;
          end
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) state_d = PARITY;
        end
        PARITY: begin
          par_d   = rx_bit;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (rx_bit) frame_done = 1'b1;
          else        stop_bad   = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A transfer in the completion cycle frees the buffer for back-to-back reload.
  assign buf_free = !out_valid_q || out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_perr_d  = out_perr_q;
    frame_err_d = stop_bad;
    overrun_d   = 1'b0;
    cnt_d       = cnt_q;
    if (frame_done && buf_free) begin
      out_valid_d = 1'b1;
      out_data_d  = shift_q;
      out_perr_d  = perr;
      if (perr && (cnt_q != CNT_MAX)) cnt_d = cnt_q + CNT_W'(1);
    end else if (frame_done) begin
      overrun_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    if (clr_count) cnt_d = '0;
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_perr   = out_perr_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign perr_count = cnt_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_even_parity_frame_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_even_parity_frame_ctrl : directed + randomized frames against a
// frame-level reference model. Rev 1.0
// ----------------------------------------------------------------------------
module tb_even_parity_frame_ctrl;

  localparam int DW   = 4;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b0;
  logic          bit_en    = 1'b0;
  logic          rx_bit    = 1'b1;
  logic          out_ready = 1'b0;
  logic          clr_count = 1'b0;
  logic          out_valid;
  logic          out_perr;
  logic          frame_err;
  logic          overrun;
  logic          busy;
  logic [DW-1:0] out_data;
  logic [CW-1:0] perr_count;

  int n_cmp = 0;
  int n_err = 0;

  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic          m_perr  = 1'b0;
  logic          m_ferr  = 1'b0;
  logic          m_over  = 1'b0;
  logic          m_busy  = 1'b0;
  int            m_cnt   = 0;
  bit            rnd_rdy = 1'b0;
  bit            rnd_clr = 1'b0;

  even_parity_frame_ctrl #(
    .DATA_W (DW),
    .CNT_W  (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_en     (bit_en),
    .rx_bit     (rx_bit),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_perr   (out_perr),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .perr_count (perr_count),
    .clr_count  (clr_count),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("out_valid",  32'(out_valid),  32'(m_valid));
    chk("out_data",   32'(out_data),   32'(m_data));
    chk("out_perr",   32'(out_perr),   32'(m_perr));
    chk("frame_err",  32'(frame_err),  32'(m_ferr));
    chk("overrun",    32'(overrun),    32'(m_over));
    chk("perr_count", 32'(perr_count), 32'(m_cnt));
    chk("busy",       32'(busy),       32'(m_busy));
  endtask

  // One clock: the model is told whether this edge completes/aborts a frame.
  task automatic tick(input bit done, input bit bad, input bit busy_after,
                      input logic [DW-1:0] d, input logic p);
    if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    if (rnd_clr) clr_count = ($urandom_range(0, 15) == 0);
    @(posedge clk);
    m_ferr = bad;
    m_over = 1'b0;
    if (done) begin
      if (!m_valid || out_ready) begin
        m_valid = 1'b1;
        m_data  = d;
        m_perr  = (^d) ^ p;
        if (m_perr && m_cnt < CMAX) m_cnt++;
      end else begin
        m_over = 1'b1;
      end
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (clr_count) m_cnt = 0;
    m_busy = busy_after;
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    bit_en = 1'b0;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic stop,
                            input int gaps, input bit clr_stop);
    logic b;
    for (int k = 0; k < DW + 3; k++) begin
      if (k == 0)            b = 1'b0;
      else if (k <= DW)      b = d[k-1];
      else if (k == DW + 1)  b = p;
      else                   b = stop;
      for (int g = 0; g < int'($urandom_range(0, gaps)); g++) begin
        bit_en = 1'b0;
        rx_bit = 1'($urandom_range(0, 1));
        tick(1'b0, 1'b0, k != 0, d, p);
      end
      bit_en = 1'b1;
      rx_bit = b;
      if (k == DW + 2 && !rnd_clr) clr_count = clr_stop;
      tick((k == DW + 2) && stop, (k == DW + 2) && !stop, k != DW + 2, d, p);
    end
    bit_en = 1'b0;
    rx_bit = 1'b1;
    if (!rnd_clr) clr_count = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    m_valid = 1'b0; m_data = '0; m_perr = 1'b0;
    m_ferr  = 1'b0; m_over = 1'b0; m_busy = 1'b0; m_cnt = 0;
    check_all();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();

    // Good frame 1010, then single-cycle transfer
    out_ready = 1'b1;
    send_frame(4'b1010, 1'b0, 1'b1, 0, 1'b0);
    idle(2);

    // Parity error counted, then a clean frame
    send_frame(4'b0001, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'b1110, 1'b1, 1'b1, 0, 1'b0);
    idle(1);

    // Full buffer: second frame dropped with overrun
    out_ready = 1'b0;
    send_frame(4'b1001, 1'b0, 1'b1, 0, 1'b0);
    send_frame(4'b0011, 1'b0, 1'b1, 0, 1'b0);
    idle(2);
    out_ready = 1'b1;
    idle(2);

    // Framing error
    send_frame(4'b0110, 1'b0, 1'b0, 0, 1'b0);
    idle(1);

    // Saturation, then clear colliding with an increment
    clr_count = 1'b1;
    idle(1);
    clr_count = 1'b0;
    for (int i = 0; i < 5; i++) send_frame(4'b0001, 1'b0, 1'b1, 1, 1'b0);
    send_frame(4'b0111, 1'b0, 1'b1, 0, 1'b1);
    idle(1);

    // Reset mid-frame, then a gapped good frame
    bit_en = 1'b1;
    rx_bit = 1'b0; tick(1'b0, 1'b0, 1'b1, '0, 1'b0);
    rx_bit = 1'b1; tick(1'b0, 1'b0, 1'b1, '0, 1'b0);
    rx_bit = 1'b0; tick(1'b0, 1'b0, 1'b1, '0, 1'b0);
    bit_en = 1'b0;
    do_reset();
    idle(2);
    send_frame(4'b1100, 1'b0, 1'b1, 3, 1'b0);
    idle(2);

    // Randomized frames with random ready and occasional clears
    rnd_rdy = 1'b1;
    rnd_clr = 1'b1;
    for (int i = 0; i < 40; i++) begin
      send_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 7) != 0), 2, 1'b0);
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end
    rnd_rdy   = 1'b0;
    rnd_clr   = 1'b0;
    clr_count = 1'b0;
    out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
